// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multiply/divide sequencing controller.
package multdiv_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StBusy  = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam int unsigned DefaultMaxCycles = 40;

  // Exception flag reported when the unit never answers.
  localparam logic TimeoutExc = 1'b1;

endpackage

// File: rtl/md_hold_reg.sv
// Enabled holding register with asynchronous active-low reset.
module md_hold_reg #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] q_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequences one mult/div op at a time: start pulse, stall, bounded wait for the
// result, and a writeback latch handed over under valid/ack with flush support.
module multdiv_ctrl
  import multdiv_pkg::*;
#(
  parameter int unsigned MaxCycles = DefaultMaxCycles
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        op_valid_i,
  input  logic        op_is_div_i,
  input  logic [31:0] op_ir_i,
  input  logic        flush_i,
  input  logic        md_ready_i,
  input  logic [31:0] md_result_i,
  input  logic        md_exception_i,
  output logic        md_ctrl_mult_o,
  output logic        md_ctrl_div_o,
  output logic        stall_o,
  output logic        wb_valid_o,
  output logic [31:0] wb_result_o,
  output logic [31:0] wb_ir_o,
  output logic        wb_exception_o,
  input  logic        wb_ack_i
);

  localparam int unsigned CntW = $clog2(MaxCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(MaxCycles - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            is_div_q, is_div_d;
  logic [31:0]     ir_q, ir_d;
  logic            exc_q, exc_d;
  logic            wb_load;
  logic [31:0]     wb_result_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_div_d    = is_div_q;
    ir_d        = ir_q;
    exc_d       = exc_q;
    wb_load     = 1'b0;
    wb_result_d = '0;
    unique case (state_q)
      StIdle: begin
        if (op_valid_i && !flush_i) begin
          is_div_d = op_is_div_i;
          ir_d     = op_ir_i;
          state_d  = StStart;
        end
      end
      StStart: begin
        if (flush_i) begin
          state_d = StIdle;
        end else begin
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        // Flush beats a result; a result beats the timeout.
        if (flush_i) begin
          state_d = StIdle;
        end else if (md_ready_i) begin
          wb_load     = 1'b1;
          wb_result_d = md_result_i;
          exc_d       = md_exception_i;
          state_d     = StDone;
        end else if (cnt_q == CntLast) begin
          wb_load = 1'b1;
          exc_d   = TimeoutExc;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (flush_i || wb_ack_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      ir_q     <= '0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      ir_q     <= ir_d;
      exc_q    <= exc_d;
    end
  end

  md_hold_reg #(
    .Width(32)
  ) u_result_reg (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .en_i  (wb_load),
    .d_i   (wb_result_d),
    .q_o   (wb_result_o)
  );

  md_hold_reg #(
    .Width(32)
  ) u_ir_reg (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .en_i  (wb_load),
    .d_i   (ir_q),
    .q_o   (wb_ir_o)
  );

  // Outputs decode flops only, so no input reaches an output combinationally.
  assign md_ctrl_mult_o = (state_q == StStart) && !is_div_q;
  assign md_ctrl_div_o  = (state_q == StStart) && is_div_q;
  assign stall_o        = (state_q != StIdle);
  assign wb_valid_o     = (state_q == StDone);
  assign wb_exception_o = exc_q;

endmodule

// File: doc/multdiv_ctrl.md
# multdiv_ctrl

Sequencing controller for the multi-cycle multiply/divide unit and its result latch feeding writeback. It accepts one mult/div operation at a time from the D/X stage and pulses the unit's start control. While the operation is in flight it stalls the pipeline. It captures the unit's result and the instruction word into a holding latch and presents them to writeback under a valid/ack handshake, with flush and timeout handling.

## Interface
- MAX_CYCLES, 40: BUSY cycles allowed before forced timeout; must be ≥1.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- op_valid  in  1  D/X presents a mult/div operation.
- op_is_div  in  1  1 = divide, 0 = multiply.
- op_ir  in  32  instruction word of the operation.
- flush  in  1  pipeline flush; aborts any operation not yet handed to writeback.
- md_ready  in  1  unit result valid (data_resultRDY).
- md_result  in  32  unit result.
- md_exception  in  1  unit exception (overflow, divide by zero).
- md_ctrl_mult  out  1  one-cycle multiply start pulse.
- md_ctrl_div  out  1  one-cycle divide start pulse.
- stall  out  1  hold the instruction behind the accepted op.
- wb_valid  out  1  result latch holds a completed operation.
- wb_result  out  32  latched result.
- wb_ir  out  32  latched instruction word.
- wb_exception  out  1  latched exception flag.
- wb_ack  in  1  writeback consumed the latch.

## Operation
- States: IDLE, START, BUSY, DONE. Reset puts the block in IDLE.
- Reset values: every output is 0, the cycle counter is 0, and the latches are 0.
- **IDLE**
  - op_valid & !flush: latch op_ir and op_is_div, then go to START.
  - op_valid & flush: the op is not accepted; stay in IDLE.
- **START** (exactly one cycle)
  - md_ctrl_div = latched op_is_div; md_ctrl_mult = !op_is_div.
  - md_ready is ignored in this state.
  - Next state BUSY; the counter clears to 0.
- **BUSY**
  - md_ready: capture md_result and md_exception, load wb_ir, go to DONE.
  - !md_ready and counter == MAX_CYCLES-1: timeout. Load wb_result = 0, wb_exception = 1, wb_ir = latched IR, go to DONE.
  - Otherwise the counter increments. Counter width is clog2(MAX_CYCLES+1); it never wraps.
  - If md_ready and the timeout condition occur in the same cycle, md_ready wins.
- **DONE**
  - wb_valid = 1; the latch contents are held stable.
  - wb_ack: go to IDLE; wb_valid drops the next cycle.
- **Flush**
  - In START or BUSY: go to IDLE and never assert wb_valid.
  - A late md_ready is then ignored. The unit is restarted by the next start pulse.
  - In DONE: discard the latch (wb_valid drops) and go to IDLE. If wb_ack arrives in the same cycle, it is still treated as a discard.
- stall = (state != IDLE).
- A new op is never accepted in the cycle that wb_ack is seen; acceptance requires IDLE.
- Reset asserted mid-operation: immediate return to IDLE, all outputs 0, no start pulse issued.

## Timing
- Registered outputs: every output is a flop driven from the state register or the latches; no input-to-output combinational path.
- Latency:
  - Edge 0: op accepted.
  - Cycle 1: START, start pulse high, stall high.
  - Cycle 2 onward: BUSY.
  - md_ready sampled at edge k → wb_valid high from cycle k+1.
  - Minimum latency from accept to wb_valid is 3 cycles.
- Timeout:
  - wb_valid rises MAX_CYCLES+2 cycles after the accept edge.
  - The worst-case stall length is MAX_CYCLES+2 cycles plus the wb_ack wait.
- Pulse widths: each start pulse is exactly one cycle and occurs exactly once per accepted op.

## Structure
- Shared package multdiv_pkg:
  - state encoding localparams (IDLE=2'd0, START=2'd1, BUSY=2'd2, DONE=2'd3);
  - the default MAX_CYCLES;
  - the timeout exception code.
- One natural sub-module: md_hold_reg, a 32-bit async-active-low-reset, enabled register. Instantiate it twice, for wb_result and wb_ir.
- The FSM, counter and control flops live in multdiv_ctrl.

## Test plan
- **Multiply:** op_valid, op_is_div=0, op_ir=0x00A1_8000. md_ready with md_result=42 two BUSY cycles later. Required: md_ctrl_mult pulses once, stall high throughout, wb_valid with wb_result=42 and wb_ir=0x00A1_8000, exception 0. wb_ack returns IDLE and stall clears.
- **Divide by zero:** op_is_div=1, md_ready with md_exception=1 and md_result=0. Required: md_ctrl_div pulse only, wb_exception=1, wb_result=0.
- **Timeout:** MAX_CYCLES=4, md_ready never asserted. Required: wb_valid 6 cycles after accept, wb_result=0, wb_exception=1. A second check asserts md_ready exactly on the timeout cycle: the real result must be latched with no exception.
- **Flush:** flush during the second BUSY cycle, then md_ready=1 with result 99. Required: return to IDLE, wb_valid never high, 99 never latched. A flush in DONE clears wb_valid.
- **Back-to-back ops:** wb_ack held low 5 cycles in DONE while op_valid stays high. Required: stall stays high and the second op is accepted only in IDLE, one cycle after wb_ack. Two distinct start pulses, and both results delivered in order.
- **Reset mid-BUSY:** reset low asynchronously. Required: all outputs 0 immediately, IDLE after release, no spurious md_ctrl pulse.
